// File: rtl/vga_reg_refresh_seq.sv
// Per-frame refresh of the VGA renderer register bank from RTC memory, triggered by VSync falling edge.
// Optional grant-wait timeout enabled by defining VGA_SEQ_TIMEOUT_EN.
module vga_reg_refresh_seq #(
  parameter int FIRST_ADDR = 1,
  parameter int LAST_ADDR  = 12,
  parameter int RD_LAT     = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       VSync,
  input  logic       MemGnt,
  input  logic [7:0] MemRdData,
  output logic       MemReq,
  output logic       MemRd,
  output logic [3:0] MemAddr,
  output logic [3:0] MemAddrIN,
  output logic [7:0] MemDataIN,
  output logic       CS_DATA,
  output logic       Busy,
  output logic       FrameDone,
  output logic       Timeout
);

  // state | meaning
  // IDLE  | waiting for VSync falling edge
  // REQ   | bus requested, waiting for grant
  // ISSUE | read strobe for current addr
  // WAIT  | read latency countdown
  // XFER  | renderer write strobe
  // DONE  | sweep complete, FrameDone pulse
  typedef enum logic [2:0] {IDLE, REQ, ISSUE, WAIT, XFER, DONE} state_t;

  localparam logic [3:0] ADDR_FIRST = 4'(FIRST_ADDR);
  localparam logic [3:0] ADDR_LAST  = 4'(LAST_ADDR);
  localparam logic [1:0] LAT_LOAD   = 2'(RD_LAT);

  state_t     state, state_next;
  logic       vs_q;
  logic [3:0] addr, addr_next;
  logic [1:0] lat_cnt, lat_next;
  logic       capture;
  logic       req_entry;
  logic       to_fire;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

`ifdef VGA_SEQ_TIMEOUT_EN
  localparam logic [6:0] TO_LAST = 7'(TIMEOUT - 1);
  logic [6:0] to_cnt;
  logic       timeout_q;

  assign to_fire = (state == REQ) && !VSync && !MemGnt && (to_cnt == TO_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (req_entry)         to_cnt <= '0;
      else if (state == REQ) to_cnt <= to_cnt + 7'd1;
      if (state == IDLE && state_next == REQ) timeout_q <= 1'b0;
      else if (to_fire)                       timeout_q <= 1'b1;
    end
  end

  assign Timeout = timeout_q;
`else
  assign to_fire = 1'b0;
  assign Timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    addr_next  = addr;
    lat_next   = lat_cnt;
    capture    = 1'b0;
    req_entry  = 1'b0;
    case (state)
      IDLE: begin
        if (vs_q && !VSync) begin
          state_next = REQ;
          addr_next  = ADDR_FIRST;
          req_entry  = 1'b1;
        end
      end
      REQ: begin
        if (VSync || to_fire) state_next = IDLE;
        else if (MemGnt)      state_next = ISSUE;
      end
      ISSUE: begin
        lat_next   = LAT_LOAD;
        state_next = VSync ? IDLE : WAIT;
      end
      WAIT: begin
        // Grant loss discards the word in flight; addr is kept so it is re-read.
        if (VSync) begin
          state_next = IDLE;
        end else if (!MemGnt) begin
          state_next = REQ;
          req_entry  = 1'b1;
        end else if (lat_cnt == 2'd1) begin
          lat_next   = 2'd0;
          capture    = 1'b1;
          state_next = XFER;
        end else begin
          lat_next = lat_cnt - 2'd1;
        end
      end
      XFER: begin
        if (VSync) begin
          state_next = IDLE;
        end else if (addr == ADDR_LAST) begin
          state_next = DONE;
        end else begin
          addr_next = addr + 4'd1;
          if (MemGnt) begin
            state_next = ISSUE;
          end else begin
            state_next = REQ;
            req_entry  = 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vs_q      <= 1'b1;
      addr      <= '0;
      lat_cnt   <= '0;
      MemReq    <= 1'b0;
      MemRd     <= 1'b0;
      MemAddr   <= '0;
      MemAddrIN <= '0;
      MemDataIN <= '0;
      CS_DATA   <= 1'b0;
      Busy      <= 1'b0;
      FrameDone <= 1'b0;
    end else begin
      vs_q      <= VSync;
      addr      <= addr_next;
      lat_cnt   <= lat_next;
      MemReq    <= state_next inside {REQ, ISSUE, WAIT, XFER};
      Busy      <= state_next inside {REQ, ISSUE, WAIT, XFER};
      MemRd     <= (state_next == ISSUE);
      CS_DATA   <= (state_next == XFER);
      FrameDone <= (state_next == DONE);
      if (state_next == ISSUE) MemAddr <= addr_next;
      if (capture) begin
        MemAddrIN <= addr;
        MemDataIN <= MemRdData;
      end
    end
  end

endmodule

// File: tb/tb_vga_reg_refresh_seq.sv
// Directed bench for vga_reg_refresh_seq: memory model returns 0x10+addr one cycle after MemRd.
// Timeout expectations switch on VGA_SEQ_TIMEOUT_EN.
module tb_vga_reg_refresh_seq;
  logic       clk = 1'b0, rst = 1'b1, vsync = 1'b1, gnt = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       mem_req, mem_rd, cs_data, busy, frame_done, timeout;
  logic [3:0] mem_addr, addr_in;
  logic [7:0] data_in;

  vga_reg_refresh_seq dut (
    .CLK(clk), .RESET(rst), .VSync(vsync), .MemGnt(gnt), .MemRdData(rd_data),
    .MemReq(mem_req), .MemRd(mem_rd), .MemAddr(mem_addr), .MemAddrIN(addr_in),
    .MemDataIN(data_in), .CS_DATA(cs_data), .Busy(busy), .FrameDone(frame_done),
    .Timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) rd_data <= 8'h10 + 8'(mem_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] cs_addr[$];
  logic [7:0] cs_dat[$];
  int         cs_cyc[$];
  int         fd_cnt = 0, fd_cyc = 0, rd_cnt = 0, first_rd_cyc = 0;

  always @(negedge clk) begin
    if (cs_data) begin
      cs_addr.push_back(addr_in);
      cs_dat.push_back(data_in);
      cs_cyc.push_back(cyc);
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (mem_rd) begin
      if (rd_cnt == 0) first_rd_cyc = cyc;
      rd_cnt++;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    cs_addr.delete();
    cs_dat.delete();
    cs_cyc.delete();
    fd_cnt = 0;
    rd_cnt = 0;
  endtask

  // Returns e = cycle count as seen on the negedge right after the falling edge is sampled.
  task automatic start_sweep(output int e);
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    e = cyc + 1;
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_count"}, cs_addr.size(), 12);
    if (cs_addr.size() == 12)
      for (int i = 0; i < 12; i++) begin
        chk({tag, "_addr"}, cs_addr[i], i + 1);
        chk({tag, "_data"}, cs_dat[i], 32'h11 + i);
      end
  endtask

  task automatic wait_rd(input logic [3:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (mem_rd && mem_addr == a) ok = 1'b1;
    end
  endtask

  int e, g;
  bit ok;

  initial begin
    tick(3);
    rst = 1'b0;
    chk("reset_outs", {mem_req, mem_rd, mem_addr, addr_in, data_in, cs_data, busy, frame_done, timeout}, 0);

    // Full sweep with grant held: FrameDone lands in the 38th cycle of the sweep.
    gnt = 1'b1;
    clear_logs();
    start_sweep(e);
    @(negedge clk);
    chk("start_memreq", mem_req, 1);
    chk("start_busy", busy, 1);
    tick(44);
    check_words("full");
    chk("full_fd_cnt", fd_cnt, 1);
    chk("full_fd_cyc", fd_cyc - e, 37);
    chk("full_idle_req", mem_req, 0);
    chk("full_idle_busy", busy, 0);

    // Grant withheld for 10 cycles after MemReq rises.
    gnt = 1'b0;
    clear_logs();
    start_sweep(e);
    @(negedge clk);
    chk("late_memreq", mem_req, 1);
    tick(10);
    chk("late_no_rd", rd_cnt, 0);
    gnt = 1'b1;
    g = cyc;
    tick(45);
    chk("late_first_rd", first_rd_cyc, g + 1);
    chk("late_first_cs", (cs_cyc.size() > 0) ? cs_cyc[0] : -1, g + 3);
    check_words("late");

    // Grant dropped during WAIT of addr 5.
    clear_logs();
    start_sweep(e);
    wait_rd(4'd5, ok);
    chk("gl_saw_rd5", ok, 1);
    @(negedge clk);
    gnt = 1'b0;
    @(negedge clk);
    chk("gl_no_cs", cs_data, 0);
    chk("gl_req_held", mem_req, 1);
    gnt = 1'b1;
    tick(45);
    check_words("gl");
    chk("gl_rd_cnt", rd_cnt, 13);
    chk("gl_fd_cnt", fd_cnt, 1);

    // VSync raised during addr 7's XFER aborts the sweep.
    clear_logs();
    start_sweep(e);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (cs_data && addr_in == 4'd7) ok = 1'b1;
    end
    chk("ab_saw_cs7", ok, 1);
    vsync = 1'b1;
    @(negedge clk);
    chk("ab_memreq", mem_req, 0);
    chk("ab_busy", busy, 0);
    tick(20);
    chk("ab_cs_cnt", cs_addr.size(), 7);
    chk("ab_fd_cnt", fd_cnt, 0);
    clear_logs();
    start_sweep(e);
    tick(45);
    check_words("restart");

    // Reset during WAIT of addr 3.
    clear_logs();
    start_sweep(e);
    wait_rd(4'd3, ok);
    chk("rs_saw_rd3", ok, 1);
    @(negedge clk);
    rst = 1'b1;
    vsync = 1'b1;
    @(negedge clk);
    chk("rs_outs", {mem_req, mem_rd, mem_addr, addr_in, data_in, cs_data, busy, frame_done, timeout}, 0);
    rst = 1'b0;
    tick(20);
    chk("rs_cs_cnt", cs_addr.size(), 2);
    chk("rs_fd_cnt", fd_cnt, 0);

    // Grant never arrives.
    gnt = 1'b0;
    clear_logs();
    start_sweep(e);
    @(negedge clk);
`ifdef VGA_SEQ_TIMEOUT_EN
    tick(63);
    chk("to_req_before", mem_req, 1);
    chk("to_flag_before", timeout, 0);
    @(negedge clk);
    chk("to_req_after", mem_req, 0);
    chk("to_flag_after", timeout, 1);
    chk("to_busy_after", busy, 0);
`else
    tick(80);
    chk("nto_req", mem_req, 1);
    chk("nto_flag", timeout, 0);
    vsync = 1'b1;
    @(negedge clk);
    chk("nto_abort_req", mem_req, 0);
`endif
    chk("nto_no_rd", rd_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_reg_refresh_seq.md
# vga_reg_refresh_seq

Sequencer that refreshes the VGA pointer renderer's temporary register bank (clock, date, timer, flags, cursor) from the shared RTC data memory once per frame. On each vertical-sync assertion it requests the memory from the bus arbiter and sweeps addresses FIRST_ADDR..LAST_ADDR. Each word is delivered to the renderer as a MemAddrIN/MemDataIN/CS_DATA write strobe, all inside the blanking window. It sits between the memory arbiter and the VGA pointer/renderer block.

## Interface
- FIRST_ADDR, 1, first register-bank address swept
- LAST_ADDR, 12, last address swept, inclusive; must be ≥ FIRST_ADDR
- RD_LAT, 1, memory read latency in cycles, 1..3
- TIMEOUT, 64, grant-wait limit in cycles; only used with VGA_SEQ_TIMEOUT_EN
- CLK input 1: single clock; all logic on posedge
- RESET input 1: synchronous, active-high
- VSync input 1: active-low sync from the VGA timing generator
- MemGnt input 1: grant from the shared-memory arbiter
- MemRdData input 8: read data, valid RD_LAT cycles after the MemRd cycle
- MemReq output 1: bus request, held for the whole sweep
- MemRd output 1: one-cycle read strobe
- MemAddr output 4: memory read address
- MemAddrIN output 4: renderer bank address
- MemDataIN output 8: renderer bank data
- CS_DATA output 1: one-cycle renderer write strobe
- Busy output 1: high from sweep start to DONE or abort
- FrameDone output 1: one-cycle pulse when a sweep completes
- Timeout output 1: sticky; cleared at the next sweep start (only with the macro)

## Operation
- VSync is registered into vs_q. A sweep starts on a falling edge: vs_q=1 and VSync=0 while in IDLE.
- FSM states: IDLE, REQ, ISSUE, WAIT, XFER, DONE.
  - IDLE: all strobes low. On VSync falling edge: addr←FIRST_ADDR, MemReq←1, Busy←1, go to REQ.
  - REQ: wait for MemGnt=1, then go to ISSUE.
  - ISSUE: MemRd=1 and MemAddr=addr for one cycle. Load lat_cnt←RD_LAT. Go to WAIT.
  - WAIT: lat_cnt decrements each cycle. When it reaches 0, MemDataIN←MemRdData and MemAddrIN←addr, then go to XFER.
  - XFER: CS_DATA=1 for one cycle.
    - If addr==LAST_ADDR, go to DONE.
    - Else addr←addr+1. Go to ISSUE if MemGnt=1, else go to REQ.
  - DONE: MemReq←0, Busy←0, FrameDone=1 for one cycle, then go to IDLE.
- Grant loss: if MemGnt drops during WAIT, the word in flight is discarded. CS_DATA is not pulsed, and the FSM returns to REQ with the same addr, so that address is re-read.
- Abort: if VSync returns high in any state other than IDLE or DONE, the sweep stops.
  - The next cycle is IDLE with MemReq=0 and Busy=0, and no FrameDone pulse.
  - A CS_DATA pulse already in its XFER cycle still completes.
- A VSync falling edge during an active sweep is ignored.
- addr is 4 bits and never wraps; the LAST_ADDR comparison terminates the sweep.
- MemAddrIN and MemDataIN hold their last values between strobes.

## Timing
- Reset values: MemReq=0, MemRd=0, MemAddr=0, MemAddrIN=0, MemDataIN=0, CS_DATA=0, Busy=0, FrameDone=0, Timeout=0. The FSM goes to IDLE and vs_q←1.
- RESET mid-sweep takes effect on the next posedge and overrides everything; no further strobes are issued.
- Start latency: MemReq rises 1 cycle after the VSync falling edge is sampled.
- Per-word cost with grant held: RD_LAT+2 cycles (ISSUE, RD_LAT×WAIT, XFER).
- Full sweep, default parameters, grant immediate: 1 (REQ) + 12×3 + 1 (DONE) = 38 cycles.
- All outputs are registered and change only on posedge, so the renderer can sample them on negedge.

## Configuration
- VGA_SEQ_TIMEOUT_EN: with this macro defined, a 7-bit counter runs while in REQ.
  - If TIMEOUT cycles pass without MemGnt, the sweep aborts: IDLE, MemReq=0, Timeout←1.
  - The counter resets on every entry to REQ.
- Without the macro, REQ waits indefinitely and Timeout is tied to 0.

## Test plan
- Reset then VSync 1→0 with MemGnt tied 1 and memory[a]=0x10+a: 12 CS_DATA pulses with MemAddrIN=1..12 and MemDataIN=0x11..0x1C. FrameDone occurs 38 cycles after the edge.
- MemGnt held 0 for 10 cycles after MemReq rises, then 1: the first MemRd occurs on the cycle after grant, and no CS_DATA is pulsed before it.
- MemGnt dropped during WAIT of addr 5: no CS_DATA for the aborted read; addr 5 is re-read after regrant, and the sequence 1..12 is delivered with no gaps or duplicates.
- VSync raised after addr 7's CS_DATA: no strobe for addr 8, MemReq=0, Busy=0, no FrameDone. A new falling edge restarts at addr 1.
- RESET asserted during WAIT of addr 3: next cycle all outputs equal their reset values; no CS_DATA for addr 3.
- With VGA_SEQ_TIMEOUT_EN and TIMEOUT=64, MemGnt held 0: MemReq drops and Timeout=1 after 64 cycles in REQ. Without the macro, MemReq stays 1.
